// File: rtl/uart_image_loader_if.sv
// Loader bus: the serial input and ack from the outside world, plus the
// byte-write port and status flags toward the image memory / NN stage.
interface uart_image_loader_if #(
    parameter int ADDR_W = 16
);
    logic              rx;
    logic              image_ack;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              image_written;
    logic              frame_err;
    logic              busy;

    // Loader side: drives the write port and status flags
    modport master (
        input  rx, image_ack,
        output wr_en, wr_addr, wr_data, image_written, frame_err, busy
    );

    // Environment side: drives the serial line and ack
    modport slave (
        output rx, image_ack,
        input  wr_en, wr_addr, wr_data, image_written, frame_err, busy
    );
endinterface

// File: rtl/uart_image_loader.sv
// UART (8N1, LSB first) receiver that writes one image frame of IMAGE_BYTES
// bytes to consecutive memory addresses, then holds until the consumer acks.
module uart_image_loader #(
    parameter int CLKS_PER_BIT = 4,
    parameter int IMAGE_BYTES  = 784,
    parameter int ADDR_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_image_loader_if.master   bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]     HALF_LAST = CW'(CLKS_PER_BIT/2 - 1);
    localparam logic [CW-1:0]     BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMAGE_BYTES - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        sync_q, sync_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [ADDR_W-1:0] byte_cnt_q, byte_cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              iw_q, iw_d;
    logic              fe_q, fe_d;
    logic              rxs;

    assign rxs = sync_q[1];

    // State register; sync resets to the idle line level so reset looks like no start bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sync_q     <= 2'b11;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            iw_q       <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            iw_q       <= iw_d;
            fe_q       <= fe_d;
        end
    end

    // Next-state: mid-bit sampling driven from the start-bit midpoint, write on good stop
    always_comb begin
        state_d    = state_q;
        sync_d     = {sync_q[0], bus.rx};
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        fe_d       = 1'b0;
        iw_d       = iw_q;

        // Flag rises the cycle after the final address is written
        if (wr_en_q && wr_addr_q == LAST_ADDR) iw_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (!rxs) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // Line back high at mid-start means a glitch, not a character
                    state_d = rxs ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = rxs;
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = byte_cnt_q;
                        wr_data_d = shift_q;
                        // Counter saturates at the last address; ack clears it
                        if (byte_cnt_q == LAST_ADDR) begin
                            state_d = S_DONE;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                            state_d    = S_IDLE;
                        end
                    end else begin
                        fe_d    = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BREAK: begin
                if (rxs) state_d = S_IDLE;
            end
            S_DONE: begin
                if (bus.image_ack) begin
                    state_d    = S_IDLE;
                    byte_cnt_d = '0;
                    iw_d       = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.wr_en         = wr_en_q;
    assign bus.wr_addr       = wr_addr_q;
    assign bus.wr_data       = wr_data_q;
    assign bus.image_written = iw_q;
    assign bus.frame_err     = fe_q;
    assign bus.busy          = (state_q != S_IDLE) && (state_q != S_DONE);
endmodule

// File: doc/uart_image_loader.md
UART_IMAGE_LOADER -- requirements
Module: uart_image_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4: clock cycles per UART bit period (even, >=4).
REQ-002 Parameter IMAGE_BYTES, default 784: bytes per image frame (28x28).
REQ-003 Parameter ADDR_W, default 16: write address width.
REQ-004 clk  input  1  single system clock, all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rx  input  1  UART serial line: idle high, 8N1, LSB first.
REQ-007 image_ack  input  1  one-cycle pulse from the downstream NN stage to release the buffer and re-arm loading.
REQ-008 wr_en  output  1  one-cycle image memory write strobe.
REQ-009 wr_addr  output  ADDR_W  image memory byte address, valid when wr_en=1.
REQ-010 wr_data  output  8  received pixel byte, valid when wr_en=1.
REQ-011 image_written  output  1  level: all IMAGE_BYTES bytes stored.
REQ-012 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-013 busy  output  1  high while a character is being received (states other than IDLE and DONE).

Function
REQ-014 rx shall pass through a 2-flop synchronizer reset to 1; all decisions use the synchronized value rxs.
REQ-015 FSM states shall be IDLE, START, DATA, STOP, BREAK and DONE.
REQ-016 IDLE: rxs=0 -> START with bit counter cleared; otherwise remain.
REQ-017 START: at count CLKS_PER_BIT/2-1, rxs=0 -> DATA with counter cleared; rxs=1 -> IDLE (glitch rejected, no write, no frame_err).
REQ-018 DATA: every CLKS_PER_BIT cycles, sample rxs into shift register bit [bit_idx], bit_idx 0..7 LSB first; after bit 7 -> STOP.
REQ-019 STOP: after CLKS_PER_BIT cycles, sample rxs; 1 -> valid byte; 0 -> frame_err pulse for one cycle, byte discarded, byte counter unchanged, -> BREAK.
REQ-020 BREAK: remain until rxs=1, then -> IDLE.
REQ-021 On a valid byte, wr_en shall pulse for exactly the cycle after the stop sample, with wr_addr = byte counter and wr_data = assembled byte; byte counter then increments.
REQ-022 Bytes shall be written to addresses 0..IMAGE_BYTES-1 in arrival order, with no gaps or duplicates.
REQ-023 When the write to address IMAGE_BYTES-1 occurs, image_written shall rise on the next cycle and the FSM shall enter DONE.
REQ-024 DONE: rx activity ignored, with no wr_en and no frame_err; image_written stays high.
REQ-025 image_ack in DONE: next cycle image_written=0, byte counter=0, FSM -> IDLE; image_ack in any other state is ignored.
REQ-026 Byte counter shall never exceed IMAGE_BYTES-1 and shall not wrap during a load.
REQ-027 Back-to-back characters (next start bit immediately after stop bit) shall be received without loss when CLKS_PER_BIT>=4.
REQ-028 wr_addr and wr_data shall be held at their last values when wr_en=0.

Reset
REQ-029 Asserting reset at any time, including mid-character, shall immediately force: FSM=IDLE, synchronizer=1, counters=0, wr_en=0, wr_addr=0, wr_data=0, image_written=0, frame_err=0, busy=0; a partial byte is discarded.
REQ-030 After reset release, the first falling edge of rxs shall begin a new character with byte address 0.

Verification
REQ-031 Reset, then send 0x5A with CLKS_PER_BIT=4 -> one wr_en pulse, wr_addr=0, wr_data=0x5A, image_written=0.
REQ-032 Send 784 back-to-back bytes (index mod 128) -> 784 wr_en pulses, addresses 0..783 in order with matching data; image_written=1 one cycle after the last write; busy=0.
REQ-033 In DONE, send 3 more bytes -> no wr_en; then pulse image_ack, send 0x11 -> image_written=0, wr_addr=0, wr_data=0x11.
REQ-034 Send a character with stop bit 0 -> frame_err for one cycle, no wr_en; hold rx low 20 cycles, then release and send 0x33 -> wr_addr=previous count, wr_data=0x33.
REQ-035 Drive a 1-cycle low glitch on rx while idle -> no wr_en, no frame_err, FSM back to IDLE.
REQ-036 Assert reset during bit 4 of a character, then send 0x7F -> wr_addr=0, wr_data=0x7F, no write of the partial byte.
